// File: rtl/if_axis_tx.sv
// Memory-mapped AXI-Stream transmitter: CPU stores fill a TX FIFO,
// a registered output stage drains it onto the master stream port.
module if_axis_tx #(
  parameter logic [7:0] SOC_SEGMENT     = 8'he4,
  parameter logic [7:0] SOC_CLASS       = 8'ha0,
  parameter int         AXIS_DATA_WIDTH = 8,
  parameter int         FIFO_DEPTH      = 4
) (
  input  logic                       axis_aclk_i,
  input  logic                       axis_areset_i,
  input  logic [31:0]                addr_i,
  input  logic [31:0]                data_i,
  input  logic                       data_w_i,
  output logic [31:0]                data_o,
  output logic                       data_access_o,
  output logic                       m_axis_tvalid_o,
  input  logic                       m_axis_tready_i,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata_o,
  output logic                       m_axis_tlast_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = AXIS_DATA_WIDTH + 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t state_q, state_d;

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   data_q, data_d;
  logic [AXIS_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic          tlast_q, tlast_d;

  logic [2:0]  sel;
  logic        wr, rd;
  logic        push_req, push_last, push_ok;
  logic        pop;
  logic        fifo_empty, fifo_full;
  logic        out_full, idle;
  logic [7:0]  occ;
  logic [31:0] rdata;
  logic        unused_bits;

  assign data_access_o = (addr_i[31:24] == SOC_SEGMENT)
                      && (addr_i[23:16] == SOC_CLASS);

  assign sel = addr_i[6:4];
  assign wr  = data_access_o & data_w_i;
  assign rd  = data_access_o & ~data_w_i;

  assign push_last = (sel == 3'b100);
  assign push_req  = wr & ((sel == 3'b011) | push_last);

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == DEPTH_C);

  assign unused_bits = &{1'b0, addr_i[15:7], addr_i[3:0], data_i};

  // FSM: state register
  always_ff @(posedge axis_aclk_i or posedge axis_areset_i) begin
    if (axis_areset_i) state_q <= S_EMPTY;
    else               state_q <= state_d;
  end

  // FSM: next state and pop decision
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      S_EMPTY: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (m_axis_tready_i) begin
          pop     = !fifo_empty;
          state_d = fifo_empty ? S_EMPTY : S_FULL;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // FSM: outputs
  always_comb begin
    out_full = (state_q == S_FULL);
    idle     = fifo_empty & ~out_full;
  end

  // a pop in the same cycle frees the slot a full FIFO would refuse
  assign push_ok = push_req & (~fifo_full | pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q + AW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    cnt_d    = cnt_q + (AW + 1)'(push_ok) - (AW + 1)'(pop);
    ovf_d    = ovf_q;
    if (wr && sel == 3'b001) ovf_d = 1'b0;
    if (push_req && !push_ok) ovf_d = 1'b1;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    if (pop) {tlast_d, tdata_d} = mem_q[rd_ptr_q];
  end

  assign occ = 8'(cnt_q) + {7'd0, out_full};

  always_comb begin
    rdata = '0;
    if (sel == 3'b001) begin
      rdata = {16'd0, occ, 3'd0, ovf_q, idle,
               fifo_full, m_axis_tready_i, out_full};
    end
    data_d = rd ? rdata : data_q;
  end

  always_ff @(posedge axis_aclk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= {push_last, data_i[AXIS_DATA_WIDTH-1:0]};
  end

  always_ff @(posedge axis_aclk_i or posedge axis_areset_i) begin
    if (axis_areset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      data_q   <= '0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      data_q   <= data_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
    end
  end

  assign data_o          = data_q;
  assign m_axis_tvalid_o = out_full;
  assign m_axis_tdata_o  = tdata_q;
  assign m_axis_tlast_o  = tlast_q;

endmodule

// File: tb/tb_if_axis_tx.sv
// Bench for if_axis_tx: bus stores feed a scoreboard queue,
// a stream monitor pops and compares every handshaken beat.
module tb_if_axis_tx;

  localparam logic [31:0] A_STAT = 32'he4a00010;
  localparam logic [31:0] A_DATA = 32'he4a00030;
  localparam logic [31:0] A_LAST = 32'he4a00040;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic [31:0] rdata;
  logic        acc;
  logic        tvalid;
  logic        tready = 1'b0;
  logic [7:0]  tdata;
  logic        tlast;

  int checks = 0;
  int errors = 0;
  logic [8:0] q [$];
  logic [31:0] v;

  if_axis_tx dut (
    .axis_aclk_i    (clk),
    .axis_areset_i  (rst),
    .addr_i         (addr),
    .data_i         (wdata),
    .data_w_i       (we),
    .data_o         (rdata),
    .data_access_o  (acc),
    .m_axis_tvalid_o(tvalid),
    .m_axis_tready_i(tready),
    .m_axis_tdata_o (tdata),
    .m_axis_tlast_o (tlast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    addr = a; wdata = d; we = 1'b1;
    @(posedge clk); #1;
    addr = '0; wdata = '0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] r);
    @(posedge clk); #1;
    addr = a; we = 1'b0;
    @(posedge clk); #1;
    addr = '0;
    r = rdata;
  endtask

  task automatic push(input logic [7:0] d, input logic last,
                      input logic exp_acc);
    if (exp_acc) q.push_back({last, d});
    bus_wr(last ? A_LAST : A_DATA, {24'h0, d});
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk); #1;
    tready = r;
  endtask

  always @(negedge clk) begin
    if (!rst && tvalid && tready) begin
      if (q.size() == 0) chk("beat_unexp", {23'd0, tlast, tdata}, 32'h1ff);
      else chk("beat", {23'd0, tlast, tdata}, {23'd0, q.pop_front()});
    end
  end

  initial begin
    #12;
    chk("rst_out", {22'd0, tvalid, tlast, tdata}, 32'h0);
    chk("rst_data_o", rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus_rd(A_STAT, v);
    chk("rst_status", v, 32'h8);

    // single byte, latency and one-cycle valid
    set_ready(1'b1);
    push(8'hA5, 1'b0, 1'b1);
    @(negedge clk); chk("lat_e0", {31'd0, tvalid}, 32'd0);
    @(negedge clk); chk("lat_e1", {31'd0, tvalid}, 32'd1);
    chk("single_data", {23'd0, tlast, tdata}, 32'h0a5);
    @(negedge clk); chk("lat_e2", {31'd0, tvalid}, 32'd0);

    // backpressure and ordering
    set_ready(1'b0);
    push(8'h11, 1'b0, 1'b1);
    push(8'h22, 1'b0, 1'b1);
    push(8'h33, 1'b0, 1'b1);
    push(8'h44, 1'b1, 1'b1);
    bus_rd(A_STAT, v);
    chk("bp_status", v, 32'h0401);
    @(negedge clk); chk("bp_hold", {23'd0, tlast, tdata}, 32'h011);
    @(negedge clk); chk("bp_hold", {23'd0, tlast, tdata}, 32'h011);
    set_ready(1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("b2b_valid", {31'd0, tvalid}, 32'd1);
    end
    @(negedge clk); chk("b2b_end", {31'd0, tvalid}, 32'd0);
    chk("b2b_q", q.size(), 32'd0);

    // overflow
    set_ready(1'b0);
    for (int i = 0; i < 6; i++)
      push(8'h61 + 8'(i), 1'b0, i < 5);
    bus_rd(A_STAT, v);
    chk("ovf_status", v, 32'h0515);
    bus_wr(A_STAT, 32'hffffffff);
    bus_rd(A_STAT, v);
    chk("ovf_clear", v, 32'h0505);

    // push with pop while full
    @(posedge clk); #1;
    addr = A_DATA; wdata = 32'h77; we = 1'b1; tready = 1'b1;
    q.push_back({1'b0, 8'h77});
    @(posedge clk); #1;
    addr = '0; wdata = '0; we = 1'b0; tready = 1'b0;
    bus_rd(A_STAT, v);
    chk("pushpop_status", v, 32'h0505);
    set_ready(1'b1);
    repeat (8) @(posedge clk);
    #1; tready = 1'b0;
    chk("drain_q", q.size(), 32'd0);
    bus_rd(A_STAT, v);
    chk("drain_status", v, 32'h8);

    // decode
    @(posedge clk); #1;
    addr = 32'he4b00030; wdata = 32'h99; we = 1'b1;
    #1 chk("acc_miss", {31'd0, acc}, 32'd0);
    @(posedge clk); #1;
    addr = A_STAT; we = 1'b0;
    #1 chk("acc_hit", {31'd0, acc}, 32'd1);
    @(posedge clk); #1;
    addr = '0;
    repeat (3) @(negedge clk);
    chk("miss_nopush", {31'd0, tvalid}, 32'd0);
    chk("hit_read", rdata, 32'h8);
    bus_rd(32'he4a00050, v);
    chk("undec_read", v, 32'h0);
    bus_rd(A_STAT, v);
    chk("miss_status", v, 32'h8);

    // reset mid-stream
    push(8'h5A, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    bus_rd(A_STAT, v);
    chk("pre_rst_status", v, 32'h0101);
    chk("pre_rst_out", {22'd0, tvalid, tlast, tdata}, 32'h35a);
    @(negedge clk); #1;
    rst = 1'b1;
    q.delete();
    #1;
    chk("arst_out", {22'd0, tvalid, tlast, tdata}, 32'h0);
    chk("arst_data_o", rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus_rd(A_STAT, v);
    chk("post_rst_status", v, 32'h8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
